// File: rtl/fpall_unpack_stage.sv
// rtl/fpall_unpack_stage.sv - operand unpack/classify stage with 2-entry skid buffer
module fpall_unpack_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_fmt,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic             out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_a_sign,
  output logic [15:0]      out_a_exp,
  output logic [47:0]      out_a_man,
  output logic [1:0]       out_a_zero,
  output logic [1:0]       out_a_sub,
  output logic [1:0]       out_a_inf,
  output logic [1:0]       out_a_nan,
  output logic [1:0]       out_b_sign,
  output logic [15:0]      out_b_exp,
  output logic [47:0]      out_b_man,
  output logic [1:0]       out_b_zero,
  output logic [1:0]       out_b_sub,
  output logic [1:0]       out_b_inf,
  output logic [1:0]       out_b_nan
);

  localparam logic [1:0] OP_SQRT = 2'b10;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        zero;
    logic        sub;
    logic        inf;
    logic        nan;
  } lane_t;

  typedef struct packed {
    logic [1:0]  sign;
    logic [15:0] exp;
    logic [47:0] man;
    logic [1:0]  zero;
    logic [1:0]  sub;
    logic [1:0]  inf;
    logic [1:0]  nan;
  } opnd_t;

  typedef struct packed {
    logic [1:0]       op;
    logic             fmt;
    logic [TAG_W-1:0] tag;
    opnd_t            a;
    opnd_t            b;
  } bundle_t;

  // Classify one lane. For bf16 the fraction arrives zero-extended in f[6:0].
  function automatic lane_t classify(input logic sign, input logic [7:0] e,
                                     input logic [22:0] f, input logic is_bf16);
    lane_t l;
    logic  f_nz;
    logic  e_zero;
    logic  hidden;
    f_nz   = |f;
    e_zero = (e == 8'h00);
    hidden = !e_zero;
    l.sign = sign;
    l.zero = e_zero && !f_nz;
    l.sub  = e_zero && f_nz;
    l.inf  = (e == 8'hFF) && !f_nz;
    l.nan  = (e == 8'hFF) && f_nz;
    // Subnormals carry the minimum normal exponent so the datapath needs no special case.
    l.exp  = e_zero ? (f_nz ? 8'd1 : 8'd0) : e;
    l.man  = is_bf16 ? {16'b0, hidden, f[6:0]} : {hidden, f};
    return l;
  endfunction

  function automatic opnd_t unpack(input logic [31:0] w, input logic fmt);
    lane_t l0;
    lane_t l1;
    opnd_t o;
    if (fmt) begin
      l0 = classify(w[15], w[14:7], {16'b0, w[6:0]}, 1'b1);
      l1 = classify(w[31], w[30:23], {16'b0, w[22:16]}, 1'b1);
    end else begin
      l0 = classify(w[31], w[30:23], w[22:0], 1'b0);
      l1 = '0;
    end
    o.sign = {l1.sign, l0.sign};
    o.exp  = {l1.exp, l0.exp};
    o.man  = {l1.man, l0.man};
    o.zero = {l1.zero, l0.zero};
    o.sub  = {l1.sub, l0.sub};
    o.inf  = {l1.inf, l0.inf};
    o.nan  = {l1.nan, l0.nan};
    return o;
  endfunction

  bundle_t r_r0;
  bundle_t r_r1;
  logic    r_r0_valid;
  logic    r_r1_valid;
  bundle_t w_new;
  logic    w_accept;
  logic    w_drain;

  // Build the classified bundle for the incoming request; SQRT has no b operand.
  always_comb begin
    w_new     = '0;
    w_new.op  = in_op;
    w_new.fmt = in_fmt;
    w_new.tag = in_tag;
    w_new.a   = unpack(in_a, in_fmt);
    w_new.b   = (in_op == OP_SQRT) ? '0 : unpack(in_b, in_fmt);
  end

  assign in_ready = !r_r1_valid;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_r0_valid && out_ready;

  // Skid buffer: R0 drives the outputs, R1 absorbs one bundle while R0 is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r0       <= '0;
      r_r1       <= '0;
      r_r0_valid <= 1'b0;
      r_r1_valid <= 1'b0;
    end else if (r_r1_valid) begin
      if (w_drain) begin
        r_r0       <= r_r1;
        r_r1_valid <= 1'b0;
      end
    end else if (!r_r0_valid || w_drain) begin
      r_r0_valid <= w_accept;
      if (w_accept) r_r0 <= w_new;
    end else if (w_accept) begin
      r_r1       <= w_new;
      r_r1_valid <= 1'b1;
    end
  end

  assign out_valid  = r_r0_valid;
  assign out_op     = r_r0.op;
  assign out_fmt    = r_r0.fmt;
  assign out_tag    = r_r0.tag;
  assign out_a_sign = r_r0.a.sign;
  assign out_a_exp  = r_r0.a.exp;
  assign out_a_man  = r_r0.a.man;
  assign out_a_zero = r_r0.a.zero;
  assign out_a_sub  = r_r0.a.sub;
  assign out_a_inf  = r_r0.a.inf;
  assign out_a_nan  = r_r0.a.nan;
  assign out_b_sign = r_r0.b.sign;
  assign out_b_exp  = r_r0.b.exp;
  assign out_b_man  = r_r0.b.man;
  assign out_b_zero = r_r0.b.zero;
  assign out_b_sub  = r_r0.b.sub;
  assign out_b_inf  = r_r0.b.inf;
  assign out_b_nan  = r_r0.b.nan;

endmodule

// File: doc/fpall_unpack_stage.md
# fpall_unpack_stage

Operand unpack and classify stage sitting directly upstream of the shared FPALL arithmetic datapath. It accepts one operation per cycle (op, format, two 32-bit operand words) over a valid/ready handshake. It splits each operand into per-lane sign, exponent and mantissa (hidden bit restored) and tags each lane with special-value class flags. Results are registered behind a 2-entry skid buffer, so the arithmetic core sees a fully registered, back-pressurable operand bundle.

## Interface
- TAG_W, 4, width of the opaque transaction tag passed through unchanged
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept; registered
- in_op  in  2  fp_op_e: ADD 00, MUL 01, SQRT 10, DIV 11
- in_fmt  in  1  fp_fmt_e: 0 = one FP32 value, 1 = two packed bf16 lanes (hi = [31:16], lo = [15:0])
- in_a, in_b  in  32  operand words (fp_vec_u layout)
- in_tag  in  TAG_W  passthrough tag
- out_valid  out  1  bundle valid
- out_ready  in  1  downstream accepts
- out_op, out_fmt, out_tag  out  2/1/TAG_W  registered copies
- out_{a,b}_sign  out  2  per lane, bit0 = lane0
- out_{a,b}_exp  out  16  lane0 = [7:0], lane1 = [15:8]
- out_{a,b}_man  out  48  lane0 = [23:0], lane1 = [47:24]; mantissa with hidden bit, right-aligned
- out_{a,b}_zero, _sub, _inf, _nan  out  2 each  per-lane class flags

## Operation
- Lane mapping:
  - FP32: lane0 = whole word (man = {hidden, frac[22:0]}); all lane1 fields and flags are 0.
  - bf16: lane0 = lo, lane1 = hi; man = {16'b0, hidden, frac[6:0]}.
- Classification per lane, with E = raw exponent field and F = raw fraction:
  - zero: E = 0, F = 0. Exp out = 0, man = 0.
  - sub: E = 0, F ≠ 0. Hidden bit = 0, exp out = 1.
  - inf: E = all ones, F = 0.
  - nan: E = all ones, F ≠ 0. Exp/man output raw with hidden bit = 1.
  - normal: hidden bit = 1, exp out = E.
  - Exactly one of the four flags or none (normal) is set per active lane.
- SQRT: operand b is ignored. All out_b_* fields and flags are forced to 0.
- Handshake: transfer on valid && ready at each port. Ordering is strictly FIFO.
- Skid buffer: output register R0 plus skid register R1, both holding classified bundles.
  - Accept while R0 is empty, or R0 is draining this cycle with R1 empty: the bundle goes to R0.
  - Accept while R0 is held (out_valid && !out_ready): the bundle goes to R1. in_ready = 0 from the next cycle.
  - R0 drains while R1 is full: R1 moves to R0, R1 empties, in_ready = 1 next cycle.
  - in_ready = !R1_valid (registered state, no combinational path from out_ready).
- Output stability: while out_valid && !out_ready, all out_* signals hold constant.
- in_* values are don't-care when in_valid = 0. The stage never drops or duplicates a bundle.

## Timing
- Latency: accept at edge N produces out_valid at N+1 when R0 is empty or draining.
- Throughput: 1 op/cycle with out_ready held high.
- Reset (async, immediate): R0_valid = R1_valid = 0, out_valid = 0, in_ready = 1, all out data = 0. Reset mid-stream discards in-flight bundles.
- Simultaneous accept and drain:
  - R1 empty: the new bundle replaces R0 in the same edge.
  - R1 full: in_ready is 0, so no accept can occur.
- Capacity: at most 2 bundles in the stage. in_ready is low for exactly the cycles R1 is occupied.

## Test plan
- FP32 1.0: in_a = 0x3F800000, ADD, out_ready = 1.
  - Next cycle: lane0 sign 0, exp 0x7F, man 0x800000, all flags 0, lane1 = 0.
- bf16 pair: in_a = 0x7F800001, fmt = 1.
  - Lane1: inf = 1, exp 0xFF, man 0x80.
  - Lane0: sub = 1, exp 1, man 0x01.
- NaN and zero: in_a = 0x7FC00000, in_b = 0x80000000, MUL.
  - a: nan = 1.
  - b: zero = 1, sign 1, exp 0, man 0.
- SQRT: in_a = 0x40800000, in_b = 0xFFFFFFFF.
  - a: exp 0x81, man 0x800000.
  - All b fields and flags = 0.
- Back-pressure: out_ready = 0; send tags 1, 2, 3 on consecutive cycles.
  - Tag 1 sits in R0, tag 2 in R1; in_ready falls after tag 2 and tag 3 is held off.
  - Raise out_ready: tags emerge 1, 2, 3 in order, no loss, outputs stable while stalled.
- Reset mid-stream: assert rst with two bundles buffered.
  - out_valid = 0 and in_ready = 1 immediately.
  - After release, a new op emerges after 1 cycle with no stale data.
